// File: rtl/mandelbrot_sched.sv
// mandelbrot_sched -- pixel scheduler between a Mandelbrot iteration engine
// and a display-side pixel stream.
//
// A frame starts on `start` in IDLE. Pixels are issued to the engine one at a
// time (eng_run pulse). Each iteration result {eng_finished, eng_ctr} is
// captured into a small FIFO. That FIFO feeds the valid/ready pixel stream.
// The engine flags the last pixel of a frame with eng_finished. The frame
// ends (frame_done pulse) once the FIFO has drained.
//
// Optional feature, macro MANDELBROT_AUTOZOOM_EN:
//   When the frame ends, the offsets advance by cfg_pan_r/cfg_pan_i.
//   If auto_run=1, the next frame starts without a `start` request.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start, hold           frame request (IDLE only), issue throttle
//   cfg_cr, cfg_ci        base offsets, latched on accepted start
//   cr_offset, ci_offset  registered offsets driven to the engine
//   eng_reset, eng_run    engine reset (= !rst_n), one-cycle pixel start
//   eng_running, eng_finished, eng_ctr   engine status / result
//   pix_valid/ready/data/last            pixel stream
//   busy, frame_done, fifo_level         status
module mandelbrot_sched #(
    parameter int BITWIDTH   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          hold,
    input  logic [BITWIDTH-1:0]           cfg_cr,
    input  logic [BITWIDTH-1:0]           cfg_ci,
`ifdef MANDELBROT_AUTOZOOM_EN
    input  logic [BITWIDTH-1:0]           cfg_pan_r,
    input  logic [BITWIDTH-1:0]           cfg_pan_i,
    input  logic                          auto_run,
`endif
    output logic [BITWIDTH-1:0]           cr_offset,
    output logic [BITWIDTH-1:0]           ci_offset,
    output logic                          eng_reset,
    output logic                          eng_run,
    input  logic                          eng_running,
    input  logic                          eng_finished,
    input  logic [3:0]                    eng_ctr,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [3:0]                    pix_data,
    output logic                          pix_last,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_CAPTURE, S_DRAIN
    } state_t;

    state_t state, state_n;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          push, pop;

    assign eng_reset  = !rst_n;
    assign busy       = (state != S_IDLE);
    assign fifo_level = count;
    assign pix_valid  = (count != '0);
    assign pix_data   = mem[rptr][3:0];
    assign pix_last   = mem[rptr][4];
    assign push       = (state == S_CAPTURE);
    assign pop        = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        eng_run    = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE:    if (start) state_n = S_ISSUE;
            // The fullness check here is what keeps CAPTURE from pushing
            // into a full FIFO: with one pixel outstanding, a free slot at
            // issue time is still free at capture time.
            S_ISSUE:   if (!hold && (count != FULL_LVL)) begin
                           eng_run = 1'b1;
                           state_n = S_ARM;
                       end
            S_ARM:     if (eng_running) state_n = S_WAIT;
            S_WAIT:    if (!eng_running) state_n = S_CAPTURE;
            S_CAPTURE: state_n = eng_finished ? S_DRAIN : S_ISSUE;
            S_DRAIN:   if (count == '0) begin
                           frame_done = 1'b1;
`ifdef MANDELBROT_AUTOZOOM_EN
                           state_n = auto_run ? S_ISSUE : S_IDLE;
`else
                           state_n = S_IDLE;
`endif
                       end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cr_offset <= '0;
            ci_offset <= '0;
        end else if (state == S_IDLE && start) begin
            cr_offset <= cfg_cr;
            ci_offset <= cfg_ci;
        end
`ifdef MANDELBROT_AUTOZOOM_EN
        else if (frame_done) begin
            cr_offset <= cr_offset + cfg_pan_r;
            ci_offset <= ci_offset + cfg_pan_i;
        end
`endif
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {eng_finished, eng_ctr};
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_mandelbrot_sched.sv
module tb_mandelbrot_sched;
    localparam int BW = 10;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic clk = 1'b0;
    logic rst_n, start, hold, pix_ready;
    logic [BW-1:0] cfg_cr, cfg_ci, cr_offset, ci_offset;
`ifdef MANDELBROT_AUTOZOOM_EN
    logic [BW-1:0] cfg_pan_r, cfg_pan_i;
    logic auto_run;
`endif
    logic eng_reset, eng_run, eng_running, eng_finished;
    logic [3:0] eng_ctr, pix_data;
    logic pix_valid, pix_last, busy, frame_done;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    mandelbrot_sched #(.BITWIDTH(BW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .cfg_cr(cfg_cr), .cfg_ci(cfg_ci),
`ifdef MANDELBROT_AUTOZOOM_EN
        .cfg_pan_r(cfg_pan_r), .cfg_pan_i(cfg_pan_i), .auto_run(auto_run),
`endif
        .cr_offset(cr_offset), .ci_offset(ci_offset),
        .eng_reset(eng_reset), .eng_run(eng_run),
        .eng_running(eng_running), .eng_finished(eng_finished), .eng_ctr(eng_ctr),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_last(pix_last), .busy(busy), .frame_done(frame_done),
        .fifo_level(fifo_level)
    );

    int nvec = 0, nerr = 0;
    int runs = 0, pops = 0, dones = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Engine model: a 4x2 frame, pixel i returns ctr=i. The last pixel (i=7)
    // reports finished. eng_running stays high for 3 cycles per pixel.
    initial begin
        int idx = 0, ecnt = 0;
        eng_running = 1'b0; eng_finished = 1'b0; eng_ctr = 4'd0;
        forever begin
            @(posedge clk);
            if (eng_reset) begin
                idx = 0; ecnt = 0;
                eng_running <= 1'b0; eng_finished <= 1'b0; eng_ctr <= 4'd0;
            end else if (eng_run) begin
                eng_running <= 1'b1;
                ecnt = 3;
            end else if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0) begin
                    eng_running  <= 1'b0;
                    eng_ctr      <= 4'(idx);
                    eng_finished <= (idx == 7);
                    idx = (idx == 7) ? 0 : idx + 1;
                end
            end
        end
    end

    // Stream model: the display sees a periodic sequence 0..7, with last set
    // on 7. A reset discards everything, so the sequence restarts at 0.
    initial begin
        int exp_idx = 0;
        bit prev_stall = 0;
        logic [3:0] prev_data = '0;
        logic prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_idx = 0; prev_stall = 0;
            end else begin
                chk("valid_vs_level", int'(pix_valid), int'(fifo_level != 0));
                if (prev_stall) begin
                    chk("stall_valid", int'(pix_valid), 1);
                    chk("stall_data", int'(pix_data), int'(prev_data));
                    chk("stall_last", int'(pix_last), int'(prev_last));
                end
                if (pix_valid && pix_ready) begin
                    chk("pix_data", int'(pix_data), exp_idx);
                    chk("pix_last", int'(pix_last), int'(exp_idx == 7));
                    exp_idx = (exp_idx + 1) % 8;
                    pops++;
                end
                if (eng_run) begin
                    chk("one_outstanding", int'(eng_running), 0);
                    runs++;
                end
                if (frame_done) dones++;
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
                prev_last  = pix_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [BW-1:0] cr, input logic [BW-1:0] ci);
        cfg_cr = cr; cfg_ci = ci; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (frame_done) break;
            n++;
        end
        if (n >= 1000) chk({name, "_timeout"}, 0, 1);
        tick();
    endtask

    initial begin
        int r0, p0, d0, n;
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; pix_ready = 1'b1;
        cfg_cr = '0; cfg_ci = '0;
`ifdef MANDELBROT_AUTOZOOM_EN
        cfg_pan_r = '0; cfg_pan_i = '0; auto_run = 1'b0;
`endif
        repeat (3) tick();
        @(negedge clk);
        chk("rst_eng_reset", int'(eng_reset), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_eng_run", int'(eng_run), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_cr", int'(cr_offset), 0);

        // Full frame, display always ready; start taken on first cycle out of reset.
        tick();
        rst_n = 1'b1;
        r0 = runs; p0 = pops; d0 = dones;
        pulse_start(10'h012, 10'h034);
        chk("first_start_busy", int'(busy), 1);
        chk("eng_reset_off", int'(eng_reset), 0);
        chk("cr_latched", int'(cr_offset), 'h012);
        chk("ci_latched", int'(ci_offset), 'h034);
        wait_done("frameA");
        chk("A_pixels", pops - p0, 8);
        chk("A_runs", runs - r0, 8);
        chk("A_idle", int'(busy), 0);
        repeat (5) tick();
        chk("A_one_done", dones - d0, 1);

        // Display stalled: exactly FIFO_DEPTH pixels issued, then the scheduler
        // waits. A start while busy is ignored.
        pix_ready = 1'b0;
        r0 = runs; p0 = pops; d0 = dones;
        pulse_start(10'h0AA, 10'h011);
        repeat (100) tick();
        chk("B_runs_stalled", runs - r0, 4);
        chk("B_level_full", int'(fifo_level), 4);
        chk("B_busy", int'(busy), 1);
        pulse_start(10'h155, 10'h155);
        tick();
        chk("B_cr_kept", int'(cr_offset), 'h0AA);
        chk("B_ci_kept", int'(ci_offset), 'h011);
        pix_ready = 1'b1;
        wait_done("frameB");
        chk("B_runs", runs - r0, 8);
        chk("B_pixels", pops - p0, 8);
        repeat (5) tick();
        chk("B_one_done", dones - d0, 1);
        chk("B_idle", int'(busy), 0);

        // Hold raised while a pixel is in flight: that pixel lands, no new issue.
        r0 = runs; p0 = pops;
        pulse_start(10'h001, 10'h002);
        n = 0;
        while (!eng_running && n < 50) begin tick(); n++; end
        if (n >= 50) chk("C_running_timeout", 0, 1);
        hold = 1'b1;
        tick();
        repeat (30) tick();
        chk("C_runs_held", runs - r0, 1);
        chk("C_pixel_captured", pops - p0, 1);
        chk("C_busy", int'(busy), 1);
        hold = 1'b0;
        wait_done("frameC");
        chk("C_runs", runs - r0, 8);
        chk("C_pixels", pops - p0, 8);

        // Reset with three pixels queued: everything discarded, next frame clean.
        pix_ready = 1'b0;
        pulse_start(10'h033, 10'h044);
        n = 0;
        while (fifo_level != 3 && n < 200) begin tick(); n++; end
        if (n >= 200) chk("D_fill_timeout", 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("D_eng_reset", int'(eng_reset), 1);
        tick();
        rst_n = 1'b1;
        chk("D_level", int'(fifo_level), 0);
        chk("D_valid", int'(pix_valid), 0);
        chk("D_busy", int'(busy), 0);
        chk("D_cr", int'(cr_offset), 0);
        pix_ready = 1'b1;
        r0 = runs; p0 = pops;
        pulse_start(10'h077, 10'h066);
        wait_done("frameD");
        chk("D_runs", runs - r0, 8);
        chk("D_pixels", pops - p0, 8);
        chk("D_cr_new", int'(cr_offset), 'h077);

`ifdef MANDELBROT_AUTOZOOM_EN
        // Auto-advance: offsets pan with wrap, and the next frame starts by itself.
        repeat (3) tick();
        cfg_pan_r = 10'h020; cfg_pan_i = 10'h001; auto_run = 1'b1;
        p0 = pops;
        pulse_start(10'h3F0, 10'h100);
        wait_done("frameE1");
        chk("E_cr_wrap", int'(cr_offset), 'h010);
        chk("E_ci_pan", int'(ci_offset), 'h101);
        chk("E_auto_busy", int'(busy), 1);
        auto_run = 1'b0;
        wait_done("frameE2");
        chk("E_cr_second", int'(cr_offset), 'h030);
        chk("E_pixels", pops - p0, 16);
        tick();
        chk("E_idle", int'(busy), 0);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mandelbrot_sched.md
MANDELBROT_SCHED -- requirements
Module: mandelbrot_sched

Interface
REQ-001 SHALL have parameter BITWIDTH, default 10, width of offset configuration values.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries; power of two, >=2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin frame request, sampled only in IDLE.
REQ-006 SHALL have port hold  input  1  while high, no new pixel is issued; pixel in flight completes.
REQ-007 SHALL have ports cfg_cr, cfg_ci  input  BITWIDTH each  base offsets, latched on accepted start.
REQ-008 SHALL have ports cr_offset, ci_offset  output  BITWIDTH each  registered offsets driven to the engine.
REQ-009 SHALL have port eng_reset  output  1  active-high engine reset, equal to !rst_n.
REQ-010 SHALL have port eng_run  output  1  one-cycle pixel start pulse to the engine.
REQ-011 SHALL have ports eng_running, eng_finished  input  1 each  engine status.
REQ-012 SHALL have port eng_ctr  input  4  engine iteration result, valid when eng_running falls.
REQ-013 SHALL have ports pix_valid  output 1, pix_ready  input 1, pix_data  output 4, pix_last  output 1  pixel stream to the display side.
REQ-014 SHALL have ports busy  output 1 (state != IDLE), frame_done  output 1 (one-cycle pulse), fifo_level  output $clog2(FIFO_DEPTH)+1.

Function
REQ-015 SHALL implement states IDLE, ISSUE, ARM, WAIT, CAPTURE, DRAIN.
REQ-016 IDLE: on start=1, SHALL latch cfg_cr/cfg_ci into cr_offset/ci_offset and enter ISSUE next cycle; start in any other state SHALL be ignored.
REQ-017 ISSUE: SHALL assert eng_run for exactly one cycle and go to ARM only when hold=0 and fifo_level<FIFO_DEPTH; otherwise SHALL stay with eng_run=0.
REQ-018 ARM: SHALL wait for eng_running=1, then enter WAIT.
REQ-019 WAIT: on eng_running=0, SHALL enter CAPTURE.
REQ-020 CAPTURE: SHALL push {eng_finished, eng_ctr} into the FIFO in that cycle; if eng_finished=1, go to DRAIN, else ISSUE.
REQ-021 DRAIN: when FIFO empties, SHALL pulse frame_done for one cycle and return to IDLE.
REQ-022 At most one pixel SHALL be outstanding; the ISSUE fullness check guarantees CAPTURE never pushes into a full FIFO.
REQ-023 pix_valid SHALL equal FIFO non-empty; pix_data/pix_last SHALL show head entry; pop on pix_valid&&pix_ready.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 pix_data/pix_last SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-026 cr_offset/ci_offset SHALL change only on accepted start or frame advance (REQ-031).

Reset
REQ-027 With rst_n=0 at a clock edge, state SHALL become IDLE, FIFO empty, fifo_level=0, eng_run=0, frame_done=0, pix_valid=0, cr_offset=ci_offset=0.
REQ-028 Reset mid-frame SHALL discard all FIFO contents and any in-flight pixel; eng_reset=1 while rst_n=0.
REQ-029 First start SHALL be accepted in the first cycle with rst_n=1.

Configuration
REQ-030 Macro MANDELBROT_AUTOZOOM_EN SHALL select automatic frame advance; inputs cfg_pan_r, cfg_pan_i (BITWIDTH) and auto_run (1) exist only when defined.
REQ-031 With macro: at frame_done, offsets SHALL add cfg_pan_r/cfg_pan_i (modulo 2^BITWIDTH), and if auto_run=1, SHALL enter ISSUE instead of IDLE without start.
REQ-032 Without macro: offsets SHALL change only on accepted start; every frame SHALL need start.

Verification
REQ-033 Engine model 4x2 pixels, ctr=i: start, pix_ready=1 -> 8 pixels data 0..7, pix_last only on 8th, one frame_done, then busy=0.
REQ-034 pix_ready=0 whole frame, FIFO_DEPTH=4 -> exactly 4 eng_run pulses, fifo_level=4, stalls; raise pix_ready -> remaining 4 issued, order preserved.
REQ-035 hold=1 during WAIT -> current pixel captured, no next eng_run until hold=0.
REQ-036 rst_n=0 for one cycle after 3 pixels queued -> fifo_level=0, pix_valid=0, state IDLE next cycle; new start runs normally.
REQ-037 start while busy, cfg_cr=0x155 -> ignored; cr_offset keeps value latched at frame start.
REQ-038 MANDELBROT_AUTOZOOM_EN, cfg_cr=0x3F0, cfg_pan_r=0x020, auto_run=1 -> second frame cr_offset=0x010 (wrap), no start needed.
